ddr_test_rw_scheduler: RTL and testbench

//  Sequences the DDR3 self-test traffic on the MIG native (app_*) interface in the ddr_ui_clk domain.

---
 rtl/ddr_test_pkg.sv | 20 ++
 rtl/ddr_test_rw_scheduler.sv | 169 ++++++++++++++++
 tb/tb_ddr_test_rw_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR3 self-test read/write scheduler:
// MIG command codes, FSM state encoding and default burst geometry.
package ddr_test_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int ADDR_STEP_DEF = 8;
    localparam int BURST_LEN_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARB      = 3'd1,
        S_WR_BURST = 3'd2,
        S_RD_BURST = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/ddr_test_rw_scheduler.sv
// Drives DDR3 self-test traffic on the MIG app_* interface: fixed-length write bursts
// fed from the test FIFO, interleaved round-robin with read-back bursts of written data.
module ddr_test_rw_scheduler
    import ddr_test_pkg::*;
#(
    parameter int ADDR_W      = 28,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_STEP   = ADDR_STEP_DEF,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int TOTAL_BEATS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ddr3_init_done,
    input  logic              test_start,
    input  logic [8:0]        wr_data_count,
    output logic              ddr_wr_en,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    output logic              ddr_rd_en,
    output logic              busy,
    output logic              done,
    output logic              rd_unexpected,
    output state_t            state
);

    localparam int CW = $clog2(TOTAL_BEATS + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    localparam logic [CW-1:0]     TOTAL_C = CW'(TOTAL_BEATS);
    localparam logic [CW-1:0]     BL_C    = CW'(BURST_LEN);
    localparam logic [BW-1:0]     BL_B    = BW'(BURST_LEN);
    localparam logic [8:0]        BL_F    = 9'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(ADDR_STEP);

    logic [CW-1:0] wr_cmd_cnt, wr_dat_cnt, rd_cmd_cnt, rd_ret_cnt;
    logic [BW-1:0] burst_cmd, burst_dat;
    logic          last_was_wr;

    logic in_wr, in_rd, cmd_acc, dat_acc, wr_elig, rd_elig;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] cnt);
        return BASE_A + ADDR_W'(cnt) * STEP_A;
    endfunction

    assign in_wr        = (state == S_WR_BURST);
    assign in_rd        = (state == S_RD_BURST);
    assign app_en       = (in_wr || in_rd) && (burst_cmd < BL_B);
    assign app_wdf_wren = in_wr && (burst_dat < BL_B);
    assign app_wdf_end  = app_wdf_wren;
    assign ddr_wr_en    = app_wdf_wren & app_wdf_rdy;
    assign ddr_rd_en    = app_rd_data_valid;
    assign cmd_acc      = app_en & app_rdy;
    assign dat_acc      = ddr_wr_en;

    // Reads may only target beats whose data has already been accepted by the MIG.
    assign wr_elig = (wr_cmd_cnt < TOTAL_C) && (wr_data_count >= BL_F);
    assign rd_elig = ((wr_dat_cnt - rd_cmd_cnt) >= BL_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wr_cmd_cnt    <= '0;
            wr_dat_cnt    <= '0;
            rd_cmd_cnt    <= '0;
            rd_ret_cnt    <= '0;
            burst_cmd     <= '0;
            burst_dat     <= '0;
            last_was_wr   <= 1'b0;
            app_addr      <= '0;
            app_cmd       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_unexpected <= 1'b0;
        end else begin
            // A return with nothing outstanding is flagged but not counted, so the
            // return counter never overtakes the command counter.
            if (app_rd_data_valid) begin
                if (rd_ret_cnt == rd_cmd_cnt)
                    rd_unexpected <= 1'b1;
                else
                    rd_ret_cnt <= rd_ret_cnt + 1'b1;
            end

            if (!ddr3_init_done) begin
                state      <= S_IDLE;
                wr_cmd_cnt <= '0;
                wr_dat_cnt <= '0;
                rd_cmd_cnt <= '0;
                rd_ret_cnt <= '0;
                burst_cmd  <= '0;
                burst_dat  <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (test_start) begin
                            state       <= S_ARB;
                            wr_cmd_cnt  <= '0;
                            wr_dat_cnt  <= '0;
                            rd_cmd_cnt  <= '0;
                            rd_ret_cnt  <= '0;
                            burst_cmd   <= '0;
                            burst_dat   <= '0;
                            last_was_wr <= 1'b0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end
                    S_ARB: begin
                        burst_cmd <= '0;
                        burst_dat <= '0;
                        if (wr_elig && (!rd_elig || !last_was_wr)) begin
                            state       <= S_WR_BURST;
                            app_cmd     <= CMD_WR;
                            app_addr    <= addr_of(wr_cmd_cnt);
                            last_was_wr <= 1'b1;
                        end else if (rd_elig) begin
                            state       <= S_RD_BURST;
                            app_cmd     <= CMD_RD;
                            app_addr    <= addr_of(rd_cmd_cnt);
                            last_was_wr <= 1'b0;
                        end else if (rd_cmd_cnt == TOTAL_C) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_WR_BURST: begin
                        if (cmd_acc) begin
                            burst_cmd  <= burst_cmd + 1'b1;
                            wr_cmd_cnt <= wr_cmd_cnt + 1'b1;
                            app_addr   <= app_addr + STEP_A;
                        end
                        if (dat_acc) begin
                            burst_dat  <= burst_dat + 1'b1;
                            wr_dat_cnt <= wr_dat_cnt + 1'b1;
                        end
                        if ((burst_cmd == BL_B) && (burst_dat == BL_B))
                            state <= S_ARB;
                    end
                    S_RD_BURST: begin
                        if (cmd_acc) begin
                            burst_cmd  <= burst_cmd + 1'b1;
                            rd_cmd_cnt <= rd_cmd_cnt + 1'b1;
                            app_addr   <= app_addr + STEP_A;
                        end
                        if (burst_cmd == BL_B)
                            state <= S_ARB;
                    end
                    S_DRAIN: begin
                        if (rd_ret_cnt == TOTAL_C) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr_test_rw_scheduler.sv
// Directed-plus-random bench for ddr_test_rw_scheduler with a MIG/FIFO model and
// an expected command stream derived from the alternating write/read burst order.
module tb_ddr_test_rw_scheduler;
    import ddr_test_pkg::*;

    localparam int TOTAL = 4096;
    localparam int BL    = 64;
    localparam int STEP  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ddr3_init_done = 1'b1;
    logic        test_start = 1'b0;
    logic [8:0]  wr_data_count = '0;
    logic        ddr_wr_en;
    logic        app_en;
    logic [2:0]  app_cmd;
    logic [27:0] app_addr;
    logic        app_rdy = 1'b0;
    logic        app_wdf_wren;
    logic        app_wdf_end;
    logic        app_wdf_rdy = 1'b0;
    logic        app_rd_data_valid = 1'b0;
    logic        ddr_rd_en;
    logic        busy;
    logic        done;
    logic        rd_unexpected;
    state_t      state;

    always #5 clk = ~clk;

    ddr_test_rw_scheduler #(
        .ADDR_W(28), .BASE_ADDR(0), .ADDR_STEP(STEP), .BURST_LEN(BL), .TOTAL_BEATS(TOTAL)
    ) dut (
        .clk(clk), .rst(rst), .ddr3_init_done(ddr3_init_done), .test_start(test_start),
        .wr_data_count(wr_data_count), .ddr_wr_en(ddr_wr_en), .app_en(app_en),
        .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .ddr_rd_en(ddr_rd_en), .busy(busy),
        .done(done), .rd_unexpected(rd_unexpected), .state(state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int rdy_pct = 100;
    int lat     = 5;
    bit force_wdf_low = 0;
    bit force_valid   = 0;
    bit start_req     = 0;
    bit init_drv      = 1;
    bit in_run        = 0;
    int fifo_level    = 0;

    int cmd_seen, wr_seen, rd_seen, dat_seen, ret_seen;
    int rq[$];
    bit prev_cmd_stall, prev_dat_stall;
    logic [27:0] prev_addr;
    logic [2:0]  prev_cmd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        cmd_seen = 0; wr_seen = 0; rd_seen = 0; dat_seen = 0; ret_seen = 0;
        rq.delete();
        prev_cmd_stall = 0;
        prev_dat_stall = 0;
    endtask

    // One clock: drive the MIG/FIFO model at negedge, then observe what the next posedge accepts.
    task automatic step();
        bit is_wr;
        @(negedge clk);
        app_rdy       = ($urandom_range(0, 99) < rdy_pct);
        app_wdf_rdy   = !force_wdf_low && ($urandom_range(0, 99) < rdy_pct);
        wr_data_count = (fifo_level > 511) ? 9'd511 : 9'(fifo_level);
        app_rd_data_valid = force_valid;
        if (rq.size() > 0 && rq[0] <= cyc) begin
            void'(rq.pop_front());
            app_rd_data_valid = 1'b1;
            ret_seen++;
        end
        test_start     = start_req;
        start_req      = 0;
        ddr3_init_done = init_drv;
        #1;
        if (!app_wdf_rdy) chk("wr_en_no_rdy", ddr_wr_en, 1'b0);
        chk("wdf_end", app_wdf_end, app_wdf_wren);
        chk("rd_en", ddr_rd_en, app_rd_data_valid);
        if (prev_cmd_stall) chk("cmd_hold", {app_en, app_cmd, app_addr}, {1'b1, prev_cmd, prev_addr});
        if (prev_dat_stall) chk("wdf_hold", app_wdf_wren, 1'b1);
        if (app_en && app_rdy) begin
            is_wr = ((cmd_seen / BL) % 2) == 0;
            if (is_wr) begin
                chk("wr_cmd", {app_cmd, app_addr}, {3'b000, 28'(wr_seen * STEP)});
                wr_seen++;
            end else begin
                chk("rd_cmd", {app_cmd, app_addr}, {3'b001, 28'(rd_seen * STEP)});
                rd_seen++;
                rq.push_back(cyc + lat);
            end
            cmd_seen++;
        end
        if (ddr_wr_en) begin
            fifo_level--;
            dat_seen++;
        end
        if (in_run && ret_seen < TOTAL) chk("done_early", done, 1'b0);
        prev_cmd_stall = app_en && !app_rdy;
        prev_dat_stall = app_wdf_wren && !app_wdf_rdy;
        prev_addr      = app_addr;
        prev_cmd       = app_cmd;
        cyc++;
    endtask

    task automatic start_run(input bit chk_lat);
        start_req = 1;
        step();
        chk("lat_c0", app_en, 1'b0);
        step();
        chk("lat_c1", app_en, 1'b0);
        step();
        if (chk_lat) chk("lat_c2", app_en, 1'b1);
    endtask

    task automatic run_full(input int rp, input int l, input bit stall_window, input int budget);
        rdy_pct = rp;
        lat     = l;
        reset_model();
        fifo_level = TOTAL;
        in_run     = 1;
        start_run(1);
        for (int i = 0; i < budget && done !== 1'b1; i++) begin
            force_wdf_low = stall_window && (i >= 20) && (i < 30);
            step();
        end
        force_wdf_low = 0;
        in_run        = 0;
        chk("run_done", done, 1'b1);
        chk("run_busy", busy, 1'b0);
        chk("run_state", state, S_DONE);
        chk("run_wr_cmds", wr_seen, TOTAL);
        chk("run_rd_cmds", rd_seen, TOTAL);
        chk("run_all_cmds", cmd_seen, 2 * TOTAL);
        chk("run_dat_beats", dat_seen, TOTAL);
        chk("run_returns", ret_seen, TOTAL);
        chk("run_rq_empty", rq.size(), 0);
        chk("run_unexpected", rd_unexpected, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_app_en"}, app_en, 1'b0);
        chk({tag, "_wren"}, app_wdf_wren, 1'b0);
        chk({tag, "_wdf_end"}, app_wdf_end, 1'b0);
        chk({tag, "_ddr_wr_en"}, ddr_wr_en, 1'b0);
        chk({tag, "_addr"}, app_addr, 28'd0);
        chk({tag, "_cmd"}, app_cmd, 3'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_unexp"}, rd_unexpected, 1'b0);
        chk({tag, "_state"}, state, S_IDLE);
    endtask

    initial begin
        // Reset state
        reset_model();
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        // Always-ready MIG, full FIFO: alternating 64-beat write/read bursts to completion
        run_full(100, 5, 0, 20000);

        // FIFO one beat short of a burst: parked in ARB until the 64th beat lands
        rdy_pct = 100;
        lat     = 5;
        reset_model();
        fifo_level = 63;
        start_run(0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("short_fifo_no_en", app_en, 1'b0);
        end
        chk("short_fifo_state", state, S_ARB);
        fifo_level = 64;
        step();
        step();
        chk("fifo64_state", state, S_WR_BURST);
        chk("fifo64_en", app_en, 1'b1);

        // Calibration loss during a read burst
        for (int i = 0; i < 500 && !(state == S_RD_BURST && rd_seen >= 10); i++) step();
        chk("reached_rd_burst", state, S_RD_BURST);
        init_drv = 0;
        step();
        rq.delete();
        step();
        chk("init_lost_state", state, S_IDLE);
        chk("init_lost_busy", busy, 1'b0);
        chk("init_lost_en", app_en, 1'b0);
        chk("init_lost_unexp", rd_unexpected, 1'b0);
        force_valid = 1;
        step();
        force_valid = 0;
        step();
        chk("stray_read_unexp", rd_unexpected, 1'b1);
        init_drv = 1;

        // Restart after calibration loss begins at BASE_ADDR; async reset mid write burst
        reset_model();
        fifo_level = TOTAL;
        start_run(1);
        repeat (40) step();
        chk("pre_rst_state", state, S_WR_BURST);
        chk("pre_rst_wr_seen", wr_seen > 0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step();
        step();
        rst = 1'b0;

        // Random ready, 10-cycle write-data stall, 30-cycle read latency, full run
        run_full(75, 30, 1, 40000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
